// File: rtl/bm_conv_fetch.sv
// Conv-side bias fetch sequencer: issues credit-limited sequential BM reads,
// buffers the fixed-latency returns and streams them out over valid/ready.
`timescale 1ns/1ps
`ifndef BM_DEPTH
`define BM_DEPTH 256
`endif
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 32
`endif
`ifndef BM_NUM_PIPE
`define BM_NUM_PIPE 2
`endif

module bm_conv_fetch #(
    parameter int ADDR_W     = $clog2(`BM_DEPTH),
    parameter int DATA_W     = `BM_DATA_WIDTH,
    parameter int RD_LAT     = `BM_NUM_PIPE + 3,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  n_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en_conv,
    output logic [ADDR_W-1:0] rd_addr_conv,
    input  logic [DATA_W-1:0] dout_conv,
    input  logic              dout_vld_conv,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int FL_W  = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {FLUSH, IDLE, ISSUE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  issue_left_q, issue_left_d;
    logic [LEN_W-1:0]  accept_left_q, accept_left_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic              in_flush, push, stray, pop, issue, bursting;
    logic [SUM_W-1:0]  inflight;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        addr_d        = addr_q;
        issue_left_d  = issue_left_q;
        accept_left_d = accept_left_q;
        outstanding_d = outstanding_q;
        fifo_count_d  = fifo_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        rd_addr_d     = rd_addr_q;
        rd_en_d       = 1'b0;
        done_d        = 1'b0;

        in_flush = (state_q == FLUSH);
        push     = dout_vld_conv && !in_flush && (outstanding_q != '0);
        stray    = dout_vld_conv && !in_flush && (outstanding_q == '0);
        pop      = (fifo_count_q != '0) && m_ready;
        bursting = (state_q == ISSUE) || (state_q == DRAIN);
        // Reserve a FIFO slot for every read still in the BM pipe.
        inflight = SUM_W'(fifo_count_q) + SUM_W'(outstanding_q);
        issue    = (state_q == ISSUE) && (issue_left_q != '0) &&
                   (inflight < SUM_W'(FIFO_DEPTH));
        err_d    = err_q | stray;

        unique case (state_q)
            FLUSH: begin
                if (flush_cnt_q == FL_W'(RD_LAT - 1)) state_d = IDLE;
                else flush_cnt_d = flush_cnt_q + FL_W'(1);
            end
            IDLE: begin
                if (start && !done_q) begin
                    addr_d        = base_addr;
                    issue_left_d  = n_words;
                    accept_left_d = n_words;
                    if (n_words == '0) done_d = 1'b1;
                    else state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    rd_en_d      = 1'b1;
                    rd_addr_d    = addr_q;
                    addr_d       = addr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - LEN_W'(1);
                    if (issue_left_q == LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
            end
        endcase

        if (pop && bursting && (accept_left_q != '0)) begin
            accept_left_d = accept_left_q - LEN_W'(1);
            if (accept_left_q == LEN_W'(1)) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        unique case ({issue, push})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        unique case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FLUSH;
            flush_cnt_q   <= '0;
            addr_q        <= '0;
            issue_left_q  <= '0;
            accept_left_q <= '0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            addr_q        <= addr_d;
            issue_left_q  <= issue_left_d;
            accept_left_q <= accept_left_d;
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= dout_conv;
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign rd_en_conv   = rd_en_q;
    assign rd_addr_conv = rd_addr_q;
    assign m_valid      = (fifo_count_q != '0);
    assign m_data       = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bm_conv_fetch.sv
// Directed bench for bm_conv_fetch: fixed-latency BM model, stream-level
// reference model with per-cycle comparison, plus literal spot checks.
`timescale 1ns/1ps

module tb_bm_conv_fetch;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 5;
    localparam int FIFO_DEPTH = 16;
    localparam int LEN_W      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  n_words = '0;
    logic              busy, done, err;
    logic              rd_en_conv;
    logic [ADDR_W-1:0] rd_addr_conv;
    logic [DATA_W-1:0] dout_conv = '0;
    logic              dout_vld_conv = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;

    bm_conv_fetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
        .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .n_words(n_words), .busy(busy), .done(done), .err(err),
        .rd_en_conv(rd_en_conv), .rd_addr_conv(rd_addr_conv),
        .dout_conv(dout_conv), .dout_vld_conv(dout_vld_conv),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [DATA_W-1:0] bm_word(input logic [ADDR_W-1:0] a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // BM model: fixed latency, plus an injectable stray valid
    logic              pipe_v [RD_LAT];
    logic [ADDR_W-1:0] pipe_a [RD_LAT];
    bit                inject = 1'b0;

    initial begin
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = '0;
        end
    end

    always @(posedge clk) begin
        #2;
        dout_vld_conv = pipe_v[RD_LAT-1] | inject;
        dout_conv = pipe_v[RD_LAT-1] ? bm_word(pipe_a[RD_LAT-1]) : 32'hDEAD_BEEF;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0] = rd_en_conv;
        pipe_a[0] = rd_addr_conv;
    end

    // Reference model: expected read addresses and stream words per burst
    int                flush_left = 0;
    bit                in_burst = 1'b0;
    bit                exp_done = 1'b0;
    int                burst_left = 0;
    int                inflight = 0;
    int                done_seen = 0;
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];
    logic [ADDR_W-1:0] obs_addr [$];
    logic [DATA_W-1:0] obs_data [$];

    always @(negedge clk) begin
        bit nxt_done;
        bit accept;
        if (rst) begin
            flush_left = RD_LAT;
            in_burst   = 1'b0;
            exp_done   = 1'b0;
            burst_left = 0;
            inflight   = 0;
            exp_addr.delete();
            exp_data.delete();
        end else begin
            nxt_done = 1'b0;
            chk("busy", busy, (flush_left > 0) || in_burst);
            chk("done", done, exp_done);
            if (done) done_seen++;
            if (flush_left > 0) chk("flush_m_valid", m_valid, 0);
            if (rd_en_conv) begin
                obs_addr.push_back(rd_addr_conv);
                inflight++;
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got read at %0h, expected none",
                             rd_addr_conv);
                end else begin
                    chk("rd_addr", rd_addr_conv, exp_addr.pop_front());
                end
                chk("credit", inflight <= FIFO_DEPTH, 1);
            end
            if (m_valid && m_ready) begin
                obs_data.push_back(m_data);
                inflight--;
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got word %0h, expected none",
                             m_data);
                end else begin
                    chk("m_data", m_data, exp_data.pop_front());
                end
                if (burst_left > 0) begin
                    if (burst_left == 1) nxt_done = 1'b1;
                    burst_left--;
                end
            end
            accept = start && (flush_left == 0) && !in_burst && !exp_done;
            if (accept) begin
                if (n_words == '0) begin
                    nxt_done = 1'b1;
                end else begin
                    in_burst   = 1'b1;
                    burst_left = int'(n_words);
                    for (int i = 0; i < int'(n_words); i++) begin
                        exp_addr.push_back(base_addr + ADDR_W'(i));
                        exp_data.push_back(bm_word(base_addr + ADDR_W'(i)));
                    end
                end
            end
            if (nxt_done) in_burst = 1'b0;
            exp_done = nxt_done;
            if (flush_left > 0) flush_left--;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
        start     = 1'b1;
        base_addr = b;
        n_words   = n;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int max);
        int k;
        k = 0;
        while (done !== 1'b1 && k < max) begin
            step(1);
            k++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: got no done within %0d cycles, expected done", nm, max);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        done_seen = 0;
    endtask

    initial begin
        int cnt;
        step(3);
        rst = 1'b0;
        chk("rst_rd_en", rd_en_conv, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 1);
        // stray returns across the whole flush window
        step(1);
        inject = 1'b1;
        step(RD_LAT - 1);
        inject = 1'b0;
        chk("flush_exit_busy", busy, 0);
        step(1);
        chk("flush_err", err, 0);
        chk("flush_m_valid_end", m_valid, 0);

        // basic burst
        m_ready = 1'b1;
        clear_obs();
        burst(8'd5, 16'd4);
        wait_done("basic_done", 100);
        step(3);
        chk("basic_nreads", obs_addr.size(), 4);
        chk("basic_a0", obs_addr[0], 8'd5);
        chk("basic_a3", obs_addr[3], 8'd8);
        chk("basic_d0", obs_data[0], 32'h5A05_000F);
        chk("basic_ndone", done_seen, 1);

        // backpressure limits issue to FIFO_DEPTH
        m_ready = 1'b0;
        clear_obs();
        burst(8'h10, 16'd40);
        step(60);
        chk("bp_nreads", obs_addr.size(), 16);
        chk("bp_rd_en_idle", rd_en_conv, 0);
        m_ready = 1'b1;
        wait_done("bp_done", 400);
        step(3);
        chk("bp_nreads_all", obs_addr.size(), 40);
        chk("bp_npops", obs_data.size(), 40);
        chk("bp_d39", obs_data[39], 32'h5A37_00A5);
        chk("bp_ndone", done_seen, 1);

        // address wrap
        clear_obs();
        burst(8'hFE, 16'd4);
        wait_done("wrap_done", 100);
        step(3);
        chk("wrap_a0", obs_addr[0], 8'hFE);
        chk("wrap_a1", obs_addr[1], 8'hFF);
        chk("wrap_a2", obs_addr[2], 8'h00);
        chk("wrap_a3", obs_addr[3], 8'h01);

        // zero-length burst
        clear_obs();
        burst(8'd9, 16'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        step(3);
        chk("zero_nreads", obs_addr.size(), 0);
        chk("zero_ndone", done_seen, 1);

        // stray return while idle sets sticky err
        inject = 1'b1;
        step(1);
        inject = 1'b0;
        step(1);
        chk("stray_err", err, 1);
        step(2);
        chk("stray_err_sticky", err, 1);

        // reset after three reads of an eight-word burst
        m_ready = 1'b0;
        clear_obs();
        burst(8'd20, 16'd8);
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 3; k++) begin
            step(1);
            if (rd_en_conv) cnt++;
        end
        chk("mid_reads_before_rst", cnt, 3);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("mid_err_clr", err, 0);
        chk("mid_rd_en_clr", rd_en_conv, 0);
        chk("mid_m_valid_clr", m_valid, 0);
        chk("mid_done_clr", done, 0);
        step(RD_LAT + 1);
        chk("mid_flush_busy", busy, 0);
        chk("mid_stale_err", err, 0);
        chk("mid_stale_m_valid", m_valid, 0);
        m_ready = 1'b1;
        clear_obs();
        burst(8'd40, 16'd2);
        wait_done("post_rst_done", 100);
        step(3);
        chk("post_rst_npops", obs_data.size(), 2);
        chk("post_rst_a0", obs_addr[0], 8'd40);
        chk("post_rst_a1", obs_addr[1], 8'd41);
        chk("post_rst_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bm_conv_fetch.md
Name: bm_conv_fetch

Overview:
- Conv-side bias fetch sequencer. It sits directly upstream of the BM read controller's conv port.
- On a start command it issues a burst of sequential BM reads through rd_en_conv/rd_addr_conv.
- It collects the returned words on dout_conv/dout_vld_conv into a local FIFO.
- It presents the words to the conv datapath over a valid/ready stream.
- Credit-based issue guarantees the FIFO never overflows, despite the fixed, non-stallable read latency.

Parameters:
- ADDR_W, $clog2(`BM_DEPTH), BM word address width.
- DATA_W, `BM_DATA_WIDTH, BM word width.
- RD_LAT, `BM_NUM_PIPE+3, cycles from rd_en_conv to dout_vld_conv/dout_conv.
- FIFO_DEPTH, 16, power of 2, return buffer depth (≥ 2).
- LEN_W, 16, width of the burst length field.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  burst request pulse; accepted only when busy=0.
- base_addr  in  ADDR_W  first BM address of the burst.
- n_words  in  LEN_W  number of words in the burst (0 allowed).
- busy  out  1  high from start acceptance to done, and during the post-reset flush.
- done  out  1  one-cycle pulse when the last burst word is accepted downstream.
- err  out  1  sticky flag: a return arrived with no outstanding read.
- rd_en_conv  out  1  BM read request.
- rd_addr_conv  out  ADDR_W  BM read address.
- dout_conv  in  DATA_W  returned BM word.
- dout_vld_conv  in  1  returned word valid.
- m_data  out  DATA_W  stream data (FIFO head).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.

Behaviour:
- Reset values:
  - rd_en_conv=0, rd_addr_conv=0, m_valid=0, done=0, err=0.
  - FIFO empty; outstanding=0.
  - State=FLUSH, busy=1.
- State FLUSH:
  - Counts RD_LAT cycles after rst deasserts.
  - dout_vld_conv is dropped and does not set err; start is ignored.
  - Then goes to IDLE. This discards returns from reads issued before the reset.
- State IDLE:
  - busy=0.
  - start=1 latches base_addr into addr and n_words into issue_left and accept_left.
  - If n_words=0: done pulses the next cycle, no read is issued, stay IDLE, busy stays 0.
  - Otherwise go to ISSUE; busy=1 from the next cycle.
- State ISSUE:
  - A read is issued in a cycle only if issue_left>0 and (fifo_count + outstanding) < FIFO_DEPTH.
  - When issued, that cycle registers rd_en_conv=1 with rd_addr_conv=addr. Then addr+1 (modulo 2^ADDR_W, wraps at top), issue_left−1, outstanding+1.
  - rd_en_conv and rd_addr_conv are registered outputs; rd_en_conv is 0 in any cycle without an issue.
  - When issue_left reaches 0, go to DRAIN.
- State DRAIN: waits until accept_left=0.
- Returns (in any state except FLUSH):
  - dout_vld_conv=1 with outstanding>0: push dout_conv into the FIFO, outstanding−1.
  - dout_vld_conv=1 with outstanding=0: word dropped, err set to 1. err clears only on rst.
  - The credit rule guarantees a push never meets a full FIFO.
  - Simultaneous issue and return in the same cycle: outstanding is unchanged.
- Stream:
  - m_valid = FIFO non-empty.
  - A pop happens on m_valid && m_ready; each pop decrements accept_left.
  - Push and pop in the same cycle are both honoured: count unchanged, data order preserved.
  - Push into an empty FIFO is visible on m_valid the next cycle.
- done:
  - Pulses in the cycle after the pop that takes accept_left from 1 to 0.
  - The state returns to IDLE in that same cycle and busy falls with done.
  - A start coinciding with done is ignored.
- rst mid-burst: everything is cleared as at reset, then FLUSH. Stale returns are dropped, and no err or done is produced.
- Counter widths:
  - outstanding and fifo_count: $clog2(FIFO_DEPTH)+1 bits.
  - issue_left and accept_left: LEN_W bits.

Test Plan:
- Reset, then wait RD_LAT cycles. busy=1 throughout; pulse dout_vld_conv during the window. -> No FIFO push, err=0, busy=0 at cycle RD_LAT+1.
- base_addr=5, n_words=4, m_ready=1. -> rd_addr_conv 5,6,7,8 on consecutive cycles. m_data returns the model words in order. Exactly one done pulse after the 4th pop.
- n_words=40, FIFO_DEPTH=16, m_ready=0. -> Exactly 16 reads issued, then rd_en_conv stays 0. Raising m_ready resumes issue; all 40 words are delivered in order with no loss.
- base_addr=2^ADDR_W−2, n_words=4. -> Addresses max−1, max, 0, 1.
- n_words=0. -> No rd_en_conv; done pulses 1 cycle after start; busy never rises.
- Assert rst after 3 of 8 reads issued. -> Outputs clear, stale returns are dropped, err=0. A new burst with n_words=2 completes correctly.
